// File: rtl/shift_result_display.sv
// -----------------------------------------------------------------------------
// shift_result_display
//
// Captures the 8-bit result of the 4x4 left-shifter on a load pulse and
// converts it to three BCD digits with a sequential double-dabble engine
// (one iteration per clock, eight clocks per conversion). The last completed
// conversion drives a 4-digit multiplexed, active-low seven-segment display
// with leading-zero blanking.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   result_in  in   8   unsigned shifter result, sampled only when accepted
//   load       in   1   single-cycle capture request (ignored while busy)
//   busy       out  1   high while a conversion is in progress
//   bcd_out    out  12  {hundreds, tens, ones} of the last completed conversion
//   seg        out  7   segment drive {g,f,e,d,c,b,a}, active-low
//   an         out  4   digit enables, active-low one-hot; an[0] = ones digit
//   dp         out  1   decimal point, active-low, permanently off
//
// Parameters:
//   REFRESH_CNT  clock cycles each digit stays enabled (>= 2)
// -----------------------------------------------------------------------------
module shift_result_display #(
    parameter int REFRESH_CNT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  result_in,
    input  logic        load,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int              CNT_W        = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [6:0]      SEG_BLANK    = 7'h7F;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [19:0]      shift_q,   shift_d;    // {hundreds, tens, ones, binary}
    logic [2:0]       iter_q,    iter_d;
    logic             busy_q,    busy_d;
    logic [11:0]      bcd_q,     bcd_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       digit_q,   digit_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Double-dabble correction: a nibble >= 5 would overflow past 9 when
    // doubled, so add 3 before the shift to carry into the next decade.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes are unreachable and go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // Conversion datapath: one double-dabble iteration
    // -------------------------------------------------------------------------
    logic [19:0] adjusted;
    logic [19:0] iterated;

    always_comb begin
        adjusted = {dd_adjust(shift_q[19:16]),
                    dd_adjust(shift_q[15:12]),
                    dd_adjust(shift_q[11:8]),
                    shift_q[7:0]};
        iterated = {adjusted[18:0], 1'b0};
    end

    // -------------------------------------------------------------------------
    // Conversion FSM: next state
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        bcd_d   = bcd_q;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = {12'b0, result_in};
                    iter_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // load is deliberately not looked at here: requests that
                // arrive mid-conversion are dropped, not queued.
                shift_d = iterated;
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    bcd_d   = iterated[19:8];
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Display refresh: free-running, independent of conversion activity
    // -------------------------------------------------------------------------
    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        digit_d   = digit_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            digit_d   = digit_q + 2'd1;   // 3 -> 0 by natural wrap
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            bcd_q     <= '0;
            refresh_q <= '0;
            digit_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            iter_q    <= iter_d;
            busy_q    <= busy_d;
            bcd_q     <= bcd_d;
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
        end
    end

    // -------------------------------------------------------------------------
    // Display decode: pure function of registered digit index and bcd_q
    // -------------------------------------------------------------------------
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    assign hundreds = bcd_q[11:8];
    assign tens     = bcd_q[7:4];
    assign ones     = bcd_q[3:0];

    always_comb begin
        an  = 4'b1111;
        seg = SEG_BLANK;
        case (digit_q)
            2'd0: begin
                an  = 4'b1110;
                seg = seg_decode(ones);
            end
            2'd1: begin
                an  = 4'b1101;
                // A zero tens digit is significant when hundreds is non-zero.
                seg = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
            end
            2'd2: begin
                an  = 4'b1011;
                seg = (hundreds == 4'd0) ? SEG_BLANK : seg_decode(hundreds);
            end
            default: begin
                an  = 4'b1111;
                seg = SEG_BLANK;
            end
        endcase
    end

    assign busy    = busy_q;
    assign bcd_out = bcd_q;
    assign dp      = 1'b1;

endmodule
